// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the MEM-stage sequencing controller: FSM state
// encoding, the default memory timeout and the hard-wired zero register.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int         TIMEOUT_DEFAULT = 255;
  localparam logic [4:0] REG_ZERO        = 5'd0;

endpackage

// File: rtl/pipe_mem_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID-stage source that matches the destination
// of a load sitting in ID/EX. Register zero never creates a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       lu
);

  assign lu = ex_memread & (ex_rt != REG_ZERO) & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/pipe_mem_ctrl.sv
// MEM-stage sequencing controller: data-memory handshake FSM, held load data
// and load-use stall gating. Define MEM_TIMEOUT_EN to enable the ACCESS timeout.
module pipe_mem_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] rd_data,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        pipe_hold,
  output logic        wb_bubble,
  output logic        lu_hold,
  output logic        idex_flush,
  output logic        err
);

  state_t      r_state;
  state_t      w_nextState;
  logic        w_op;
  logic        w_lu;
  logic        w_timeout;
  logic        w_err;
  logic [31:0] r_rdData;

  assign w_op = mem_valid & (mem_read | mem_write);

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_timeout = (r_state == ACCESS) && !dmem_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_err     = r_err;

  // Counter restarts whenever a new op enters ACCESS; err is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE && w_op)
        r_cnt <= '0;
      else if (r_state == ACCESS && !dmem_ack)
        r_cnt <= r_cnt + 1'b1;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] w_unusedTimeout;

  assign w_unusedTimeout = CNT_W'(TIMEOUT);
  assign w_timeout       = 1'b0;
  assign w_err           = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_op) w_nextState = ACCESS;
      ACCESS:  if (dmem_ack || w_timeout) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pipe_hold = 1'b0;
    wb_bubble = 1'b0;
    case (r_state)
      IDLE: begin
        pipe_hold = w_op;
        wb_bubble = w_op;
      end
      ACCESS: begin
        dmem_req  = 1'b1;
        dmem_we   = mem_write;
        pipe_hold = 1'b1;
        wb_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // A timed-out load delivers zero rather than whatever is on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rdData <= '0;
    else if (r_state == ACCESS) begin
      if (w_timeout)
        r_rdData <= '0;
      else if (dmem_ack && mem_read)
        r_rdData <= dmem_rdata;
    end
  end

  hazard_detect u_hazard (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .lu         (w_lu)
  );

  // A memory stall freezes ID/EX anyway, so the load-use bubble waits for it.
  assign lu_hold    = w_lu & ~pipe_hold;
  assign idex_flush = w_lu & ~pipe_hold;
  assign rd_data    = r_rdData;
  assign err        = w_err;

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
// Self-checking bench for pipe_mem_ctrl: directed and randomized memory ops
// and load-use hazards against a cycle-timeline reference model.
module tb_pipe_mem_ctrl;

  localparam int TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_read, mem_write;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_rdata, rd_data;
  logic        ex_memread;
  logic [4:0]  ex_rt, id_rs, id_rt;
  logic        pipe_hold, wb_bubble, lu_hold, idex_flush, err;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] modelRd;
  logic        modelErr;
  bit          randomHazard;
  logic        hzMemread;
  logic [4:0]  hzRt, hzRs, hzRtId;

  always #5 clk = ~clk;

  pipe_mem_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_valid  (mem_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .rd_data    (rd_data),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .pipe_hold  (pipe_hold),
    .wb_bubble  (wb_bubble),
    .lu_hold    (lu_hold),
    .idex_flush (idex_flush),
    .err        (err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // A load in ID/EX stalls ID when it writes a nonzero register that ID reads.
  function automatic logic modelLoadUse();
    return hzMemread && (hzRt != 5'd0) && ((hzRt == hzRs) || (hzRt == hzRtId));
  endfunction

  task automatic applyStimulus(input logic v, input logic r, input logic w,
                               input logic a, input logic [31:0] rdata);
    @(negedge clk);
    mem_valid  = v;
    mem_read   = r;
    mem_write  = w;
    dmem_ack   = a;
    dmem_rdata = rdata;
    if (randomHazard) begin
      hzMemread = 1'($urandom_range(0, 1));
      hzRt      = 5'($urandom_range(0, 3));
      hzRs      = 5'($urandom_range(0, 3));
      hzRtId    = 5'($urandom_range(0, 3));
    end
    ex_memread = hzMemread;
    ex_rt      = hzRt;
    id_rs      = hzRs;
    id_rt      = hzRtId;
    #1;
  endtask

  task automatic checkCycle(input string tag, input logic eReq, input logic eWe,
                            input logic eHold, input logic eBub);
    logic eLu;
    eLu = modelLoadUse() & ~eHold;
    checkOutput({tag, ".dmem_req"},   {31'b0, dmem_req},   {31'b0, eReq});
    checkOutput({tag, ".dmem_we"},    {31'b0, dmem_we},    {31'b0, eWe});
    checkOutput({tag, ".pipe_hold"},  {31'b0, pipe_hold},  {31'b0, eHold});
    checkOutput({tag, ".wb_bubble"},  {31'b0, wb_bubble},  {31'b0, eBub});
    checkOutput({tag, ".lu_hold"},    {31'b0, lu_hold},    {31'b0, eLu});
    checkOutput({tag, ".idex_flush"}, {31'b0, idex_flush}, {31'b0, eLu});
    checkOutput({tag, ".rd_data"},    rd_data,             modelRd);
    checkOutput({tag, ".err"},        {31'b0, err},        {31'b0, modelErr});
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom);
    checkCycle(tag, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One op's life in MEM: detect, N+1 ACCESS cycles (ack on the last), DONE.
  task automatic runOp(input string tag, input logic isRd, input logic isWr, input int n,
                       input logic [31:0] data, input bit expectTimeout, input bit skipDetect);
    int accessCycles;
    bit ackNow;
    accessCycles = expectTimeout ? TB_TIMEOUT : n + 1;
    if (!skipDetect) begin
      applyStimulus(1'b1, isRd, isWr, 1'($urandom_range(0, 1)), $urandom);
      checkCycle({tag, ".detect"}, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    for (int i = 0; i < accessCycles; i++) begin
      ackNow = !expectTimeout && (i == n);
      applyStimulus(1'b1, isRd, isWr, ackNow, ackNow ? data : $urandom);
      checkCycle({tag, ".access"}, 1'b1, isWr, 1'b1, 1'b1);
    end
    if (expectTimeout) begin
      modelRd  = 32'h0;
      modelErr = 1'b1;
    end else if (isRd) begin
      modelRd = data;
    end
    applyStimulus(1'b1, isRd, isWr, 1'($urandom_range(0, 1)), $urandom);
    checkCycle({tag, ".done"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit   isRd;
    int   n;
    rst_n        = 1'b0;
    mem_valid    = 1'b1;
    mem_read     = 1'b1;
    mem_write    = 1'b0;
    dmem_ack     = 1'b0;
    dmem_rdata   = 32'h0;
    randomHazard = 1'b0;
    hzMemread    = 1'b0;
    hzRt         = 5'd0;
    hzRs         = 5'd0;
    hzRtId       = 5'd0;
    ex_memread   = 1'b0;
    ex_rt        = 5'd0;
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    modelRd      = 32'h0;
    modelErr     = 1'b0;

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    #1;
    checkCycle("reset", 1'b0, 1'b0, 1'b1, 1'b1);
    mem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed load and store");
    runOp("load0", 1'b1, 1'b0, 0, 32'h12345678, 1'b0, 1'b0);
    idleCycle("idle1");
    runOp("store4", 1'b0, 1'b1, 4, 32'hdeadbeef, 1'b0, 1'b0);
    runOp("b2bLoad", 1'b1, 1'b0, 2, 32'h0f0f1234, 1'b0, 1'b0);
    idleCycle("idle2");

    $display("[TB] load-use hazards");
    hzMemread = 1'b1; hzRt = 5'd5; hzRs = 5'd5; hzRtId = 5'd9;
    idleCycle("luHit");
    checkOutput("luHit.direct", {31'b0, lu_hold}, 32'd1);
    hzRt = 5'd0; hzRs = 5'd0; hzRtId = 5'd0;
    idleCycle("luZero");
    checkOutput("luZero.direct", {31'b0, idex_flush}, 32'd0);
    hzRt = 5'd7; hzRs = 5'd3; hzRtId = 5'd7;
    runOp("luDuringLoad", 1'b1, 1'b0, 3, 32'hcafef00d, 1'b0, 1'b0);
    idleCycle("luAfter");

    $display("[TB] reset mid-access");
    hzMemread = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
    checkCycle("rstMid.detect", 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, $urandom);
    checkCycle("rstMid.access", 1'b1, 1'b0, 1'b1, 1'b1);
    #2;
    rst_n   = 1'b0;
    modelRd = 32'h0;
    #1;
    checkCycle("rstMid.async", 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkCycle("rstMid.release", 1'b0, 1'b0, 1'b1, 1'b1);
    runOp("rstMid.retry", 1'b1, 1'b0, 1, 32'h0badf00d, 1'b0, 1'b1);

    $display("[TB] randomized ops");
    randomHazard = 1'b1;
    repeat (40) begin
      isRd = 1'($urandom_range(0, 1));
      n    = int'($urandom_range(0, 5));
      runOp("rand", isRd, ~isRd, n, $urandom, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) idleCycle("randIdle");
    end

`ifdef MEM_TIMEOUT_EN
    $display("[TB] timeout");
    runOp("timeout", 1'b1, 1'b0, 0, 32'h0, 1'b1, 1'b0);
    runOp("afterTimeout", 1'b1, 1'b0, 1, 32'h55aa55aa, 1'b0, 1'b0);
    idleCycle("stickyErr");
    @(negedge clk);
    mem_valid = 1'b0;
    rst_n     = 1'b0;
    modelRd   = 32'h0;
    modelErr  = 1'b0;
    #1;
    checkOutput("timeoutReset.err", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    idleCycle("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
